bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: guarded multi-channel display bus arbiter with registered bus outputs.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise lowest eligible index wins.
module bus_arbiter #(
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int GUARD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic              lock0,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [NCH-1:0]    cs_in,
    input  logic [NCH-1:0]    dc_in,
    input  logic [NCH-1:0]    sd_in,
    output logic [NCH-1:0]    grant,
    output logic              busy,
    output logic [DW-1:0]     data_out,
    output logic              cs,
    output logic              dc,
    output logic              sd
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GUARD} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  grant_q, grant_d;
    logic [IW-1:0]   own_q, own_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            cs_q, cs_d, dc_q, dc_d, sd_q, sd_d;
    logic [NCH-1:0]  elig;
    logic [IW-1:0]   win;
    logic            found;
    int              idx;
`ifdef BUS_ARB_RR_EN
    logic [IW-1:0]   ptr_q, ptr_d;
`endif

    assign elig = lock0 ? (req & {{(NCH-1){1'b0}}, 1'b1}) : req;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
`ifdef BUS_ARB_RR_EN
            idx = (int'(ptr_q) + 1 + i) % NCH;
`else
            idx = i;
`endif
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        data_d  = '0;
        cs_d    = 1'b1;
        dc_d    = 1'b1;
        sd_d    = 1'b0;
`ifdef BUS_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: if (found) begin
                state_d = S_OWN;
                grant_d = {{(NCH-1){1'b0}}, 1'b1} << win;
                own_d   = win;
`ifdef BUS_ARB_RR_EN
                ptr_d   = win;
`endif
            end
            // Release only once the owner has finished its transaction (cs_in high).
            S_OWN: if (!req[own_q] && cs_in[own_q]) begin
                state_d = (GUARD > 0) ? S_GUARD : S_IDLE;
                grant_d = '0;
                cnt_d   = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;
            end else begin
                data_d = data_in[own_q*DW +: DW];
                cs_d   = cs_in[own_q];
                dc_d   = dc_in[own_q];
                sd_d   = sd_in[own_q];
            end
            S_GUARD: if (cnt_q == 4'd0) state_d = S_IDLE;
                     else cnt_d = cnt_q - 4'd1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            cs_q    <= 1'b1;
            dc_q    <= 1'b1;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            cs_q    <= cs_d;
            dc_q    <= dc_d;
            sd_q    <= sd_d;
        end
    end

`ifdef BUS_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= IW'(NCH - 1);
        else     ptr_q <= ptr_d;
    end
`endif

    assign grant    = grant_q;
    assign busy     = (state_q != S_IDLE);
    assign data_out = data_q;
    assign cs       = cs_q;
    assign dc       = dc_q;
    assign sd       = sd_q;
endmodule
